// File: rtl/ckpt_alloc_ctrl.sv
// Checkpoint allocator for the rename alias table: a circular queue of branch snapshots with up to two
// grants per rename group, in-order retire of resolved checkpoints and a one-cycle RAT restore on mispredict.
module ckpt_alloc_ctrl #(
  parameter int C_NUM = 4,
  localparam int CW = $clog2(C_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          br_req_1,
  input  logic          br_req_2,
  output logic          grant,
  output logic          take_checkpoint,
  output logic          dual_branch,
  output logic [CW-1:0] alloc_id_1,
  output logic [CW-1:0] alloc_id_2,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [CW-1:0] res_id,
  input  logic          res_mispredict,
  output logic          restore_rat,
  output logic [CW-1:0] restore_id,
  output logic [CW:0]   free_count
);
  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_e;
  localparam logic [CW:0] CNT_MAX = (CW+1)'(C_NUM);

  state_e           state_q, state_d;
  logic [CW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW:0]      count_q, count_d;
  logic [C_NUM-1:0] valid_q, valid_d, resolved_q, resolved_d;
  logic             restore_rat_q, restore_rat_d;
  logic [CW-1:0]    restore_id_q, restore_id_d;
  logic [CW:0]      free_count_q, free_count_d;

  logic          run, hit, mp_fire, ok_fire, retire;
  logic [CW:0]   need;
  logic [CW-1:0] tail_p1, res_dist, slot_dist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      resolved_q    <= '0;
      restore_rat_q <= 1'b0;
      restore_id_q  <= '0;
      free_count_q  <= CNT_MAX;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      resolved_q    <= resolved_d;
      restore_rat_q <= restore_rat_d;
      restore_id_q  <= restore_id_d;
      free_count_q  <= free_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mp_fire) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Resolutions naming an empty slot are ignored entirely, including for the mispredict path.
  always_comb begin
    run             = (state_q == RUN);
    res_ready       = run;
    hit             = res_valid & run & valid_q[res_id];
    mp_fire         = hit & res_mispredict;
    ok_fire         = hit & ~res_mispredict;
    need            = (CW+1)'(br_req_1) + (CW+1)'(br_req_2);
    grant           = run & ~mp_fire & (need <= (CNT_MAX - count_q));
    take_checkpoint = grant & (br_req_1 | br_req_2);
    dual_branch     = grant & br_req_1 & br_req_2;
  end

  assign alloc_id_1  = tail_q;
  assign tail_p1     = tail_q + CW'(1);
  assign alloc_id_2  = tail_p1;
  assign restore_rat = restore_rat_q;
  assign restore_id  = restore_id_q;
  assign free_count  = free_count_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    resolved_d = resolved_q;
    retire     = 1'b0;
    slot_dist  = '0;
    res_dist   = res_id - head_q;
    if (mp_fire) begin
      // Age is measured from head so a full queue (head==tail) squashes correctly.
      for (int i = 0; i < C_NUM; i++) begin
        slot_dist = CW'(i) - head_q;
        if (slot_dist >= res_dist) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      tail_d  = res_id;
      count_d = {1'b0, res_dist};
    end else begin
      if (ok_fire) resolved_d[res_id] = 1'b1;
      retire = run & valid_q[head_q] & (resolved_q[head_q] | (ok_fire & (res_id == head_q)));
      if (retire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + CW'(1);
      end
      if (take_checkpoint) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        if (dual_branch) begin
          valid_d[tail_p1]    = 1'b1;
          resolved_d[tail_p1] = 1'b0;
        end
        tail_d = tail_q + need[CW-1:0];
      end
      count_d = count_q + (take_checkpoint ? need : '0) - (CW+1)'(retire);
    end
    free_count_d  = CNT_MAX - count_d;
    restore_rat_d = mp_fire;
    restore_id_d  = mp_fire ? res_id : restore_id_q;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_MAX);
  a_restore_1cy: assert property (@(posedge clk) disable iff (rst) restore_rat_q |=> !restore_rat_q);
  a_no_grant_rc: assert property (@(posedge clk) disable iff (rst) (state_q == RECOVER) |-> !grant);

endmodule

// File: tb/tb_ckpt_alloc_ctrl.sv
// Bench for ckpt_alloc_ctrl: directed scenarios then random traffic, checked against a queue-based model.
module tb_ckpt_alloc_ctrl;
  localparam int C  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_req_1, br_req_2, res_valid, res_mispredict;
  logic [CW-1:0] res_id;
  logic          grant, take_checkpoint, dual_branch, res_ready, restore_rat;
  logic [CW-1:0] alloc_id_1, alloc_id_2, restore_id;
  logic [CW:0]   free_count;

  int checks = 0;
  int errors = 0;

  // Reference: ordered list of live checkpoint ids, oldest first.
  int mq[$];
  bit mres[C];
  int mtail;
  bit mrec, mrat;
  int mrid;

  ckpt_alloc_ctrl #(.C_NUM(C)) dut (
    .clk(clk), .rst(rst), .br_req_1(br_req_1), .br_req_2(br_req_2),
    .grant(grant), .take_checkpoint(take_checkpoint), .dual_branch(dual_branch),
    .alloc_id_1(alloc_id_1), .alloc_id_2(alloc_id_2),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_mispredict(res_mispredict),
    .restore_rat(restore_rat), .restore_id(restore_id), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < C; k++) mres[k] = 1'b0;
    mtail = 0;
    mrec  = 1'b0;
    mrat  = 1'b0;
    mrid  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br_req_1 = 1'b0; br_req_2 = 1'b0; res_valid = 1'b0; res_mispredict = 1'b0; res_id = '0;
    #1;
    chk("rst_restore_rat", restore_rat, 0);
    chk("rst_free_count", free_count, C);
    chk("rst_grant", grant, 1);
    chk("rst_res_ready", res_ready, 1);
    chk("rst_alloc_id_1", alloc_id_1, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input bit r1, input bit r2, input bit rv, input int rid, input bit mp);
    int pos, need;
    bit run, hit, mpf, g;
    br_req_1 = r1; br_req_2 = r2; res_valid = rv; res_id = CW'(rid); res_mispredict = mp;
    #1;
    run = !mrec;
    pos = -1;
    foreach (mq[k]) if (mq[k] == rid) pos = k;
    hit  = run && rv && (pos >= 0);
    mpf  = hit && mp;
    need = int'(r1) + int'(r2);
    g    = run && !mpf && (need <= C - mq.size());
    chk("grant", grant, g);
    chk("take_checkpoint", take_checkpoint, g && need > 0);
    chk("dual_branch", dual_branch, g && r1 && r2);
    chk("alloc_id_1", alloc_id_1, mtail);
    chk("alloc_id_2", alloc_id_2, (mtail + 1) % C);
    chk("res_ready", res_ready, run);
    @(posedge clk);
    if (mpf) begin
      while (mq.size() > pos) void'(mq.pop_back());
      mtail = rid;
      mrec  = 1'b1;
      mrat  = 1'b1;
      mrid  = rid;
    end else begin
      mrec = 1'b0;
      mrat = 1'b0;
      if (hit) mres[rid] = 1'b1;
      if (run && mq.size() > 0 && mres[mq[0]]) void'(mq.pop_front());
      if (g) begin
        for (int k = 0; k < need; k++) begin
          mq.push_back(mtail);
          mres[mtail] = 1'b0;
          mtail = (mtail + 1) % C;
        end
      end
    end
    #1;
    chk("restore_rat", restore_rat, mrat);
    if (mrat) chk("restore_id", restore_id, mrid);
    chk("free_count", free_count, C - mq.size());
  endtask

  initial begin
    int rid, pick;
    rst = 1'b0;
    br_req_1 = 1'b0; br_req_2 = 1'b0; res_valid = 1'b0; res_mispredict = 1'b0; res_id = '0;
    #2;
    do_reset();

    // Dual allocation fills the queue.
    step(1, 1, 0, 0, 0);
    chk("t1_free_a", free_count, 2);
    step(1, 1, 0, 0, 0);
    chk("t1_free_b", free_count, 0);

    // Full: stalls, then in-order free of id0 reopens slot 0.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);

    // Mispredict on id1 with 0,1,2 in flight.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    chk("t3_restore_id", restore_id, 1);
    step(1, 0, 1, 2, 0);
    chk("t3_free", free_count, 3);
    chk("t3_next_id", alloc_id_1, 1);
    step(1, 0, 0, 0, 0);

    // Out-of-order correct resolves retire in order.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_free", free_count, 4);

    // Full queue: alloc request and head resolve in one cycle.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 3, 0);
    step(1, 0, 0, 0, 0);

    // Dropped mispredict on an empty slot, then reset during recovery.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 2, 1);
    chk("t6_restore_live", restore_rat, 1);
    do_reset();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      pick = $urandom_range(0, 3);
      if (mq.size() > 0 && pick != 0) rid = mq[$urandom_range(0, mq.size() - 1)];
      else rid = $urandom_range(0, C - 1);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rid, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
